// File: rtl/sme_sbox_sched_pkg.sv
// Shared types and constants for the masked inverse S-box scheduler.
package sme_pkg;

  localparam int unsigned XW = 21;
  localparam int unsigned YW = 18;

  typedef enum logic [1:0] {IDLE, RAND, EXEC, RESP} state_e;

  // Guard words needed by an SMAX-share multiplier: one per share plus one per share pair.
  function automatic int unsigned rmax(input int unsigned smax);
    return smax + smax * (smax - 1) / 2;
  endfunction

endpackage

// File: rtl/sme_sbox_sched_rr_arb.sv
// Round-robin arbiter: grants the lowest requesting index at or after ptr_i, wrapping.
module sme_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   nxt_ptr_o
);

  always_comb begin : arb
    logic [PW-1:0] idx;
    logic          found;
    found     = 1'b0;
    idx       = '0;
    gnt_o     = '0;
    nxt_ptr_o = ptr_i;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PW'((32'(ptr_i) + k) % NREQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        nxt_ptr_o  = PW'((32'(idx) + 1) % NREQ);
      end
    end
  end

endmodule

// File: rtl/sme_sbox_sched.sv
// Shares one masked inverse-S-box middle stage among NREQ requesters, fetching
// fresh guard randomness for every operation before enabling the datapath.
module sme_sbox_sched
  import sme_pkg::*;
#(
  parameter int unsigned SMAX = 3,
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 3,
  parameter int unsigned RW   = 32
) (
  input  logic                       g_clk,
  input  logic                       g_rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*SMAX*XW-1:0]    req_x,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [SMAX*YW-1:0]         rsp_y,
  input  logic                       rng_valid,
  input  logic [RW-1:0]              rng_data,
  output logic                       rng_ready,
  output logic                       dp_en,
  output logic [SMAX*XW-1:0]         dp_x,
  output logic [rmax(SMAX)*RW-1:0]   dp_rng,
  input  logic [SMAX*YW-1:0]         dp_y,
  output logic                       busy
);

  localparam int unsigned RMAX = rmax(SMAX);
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam int unsigned EW   = (LAT > 1) ? $clog2(LAT) : 1;

  state_e                           state_q;
  logic [PW-1:0]                    rr_q;
  logic [PW-1:0]                    rr_nxt;
  logic [NREQ-1:0]                  gnt_q;
  logic [NREQ-1:0]                  arb_gnt;
  logic [CW-1:0]                    cnt_q;
  logic [EW-1:0]                    ex_q;
  logic [RMAX-1:0][RW-1:0]          rng_q;
  logic [SMAX*XW-1:0]               x_q;
  logic [SMAX*YW-1:0]               y_q;
  logic [NREQ-1:0][SMAX*XW-1:0]     req_x_v;
  logic [SMAX*XW-1:0]               x_sel;

  assign req_x_v = req_x;

  sme_rr_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_q),
    .gnt_o     (arb_gnt),
    .nxt_ptr_o (rr_nxt)
  );

  always_comb begin
    x_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) x_sel = req_x_v[i];
    end
  end

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ex_q    <= '0;
      rng_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            x_q     <= x_sel;
            gnt_q   <= arb_gnt;
            rr_q    <= rr_nxt;
            state_q <= RAND;
          end
        end
        RAND: begin
          if (rng_valid) begin
            rng_q[cnt_q] <= rng_data;
            if (cnt_q == CW'(RMAX - 1)) begin
              cnt_q   <= '0;
              state_q <= EXEC;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        EXEC: begin
          // The datapath result is only valid on its final enabled cycle.
          if (ex_q == EW'(LAT - 1)) begin
            ex_q    <= '0;
            y_q     <= dp_y;
            state_q <= RESP;
          end else begin
            ex_q <= ex_q + EW'(1);
          end
        end
        RESP: begin
          if (|(rsp_ready & gnt_q)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE && !g_rst) ? arb_gnt : '0;
  assign rsp_valid = (state_q == RESP) ? gnt_q : '0;
  assign rng_ready = (state_q == RAND);
  assign dp_en     = (state_q == EXEC);
  assign busy      = (state_q != IDLE);
  assign dp_x      = x_q;
  assign dp_rng    = rng_q;
  assign rsp_y     = y_q;

endmodule

// File: tb/tb_sme_sbox_sched.sv
// Directed and randomized bench for sme_sbox_sched with a stand-in datapath model.
module tb_sme_sbox_sched;

  localparam int unsigned SMAX = 3;
  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 3;
  localparam int unsigned RW   = 32;
  localparam int unsigned RMAX = 6;

  logic               g_clk = 1'b0;
  logic               g_rst;
  logic [NREQ-1:0]    req_valid;
  logic [251:0]       req_x;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [53:0]        rsp_y;
  logic               rng_valid;
  logic [RW-1:0]      rng_data;
  logic               rng_ready;
  logic               dp_en;
  logic [62:0]        dp_x;
  logic [191:0]       dp_rng;
  logic [53:0]        dp_y;
  logic               busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rr_m    = 0;
  bit          ctr_mode = 1'b0;
  logic [31:0] ctr = '0;
  int          rng_hs = 0;
  int unsigned en_cnt;

  always #5 g_clk = ~g_clk;

  sme_sbox_sched #(
    .SMAX (SMAX),
    .NREQ (NREQ),
    .LAT  (LAT),
    .RW   (RW)
  ) dut (
    .g_clk     (g_clk),
    .g_rst     (g_rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rng_valid (rng_valid),
    .rng_data  (rng_data),
    .rng_ready (rng_ready),
    .dp_en     (dp_en),
    .dp_x      (dp_x),
    .dp_rng    (dp_rng),
    .dp_y      (dp_y),
    .busy      (busy)
  );

  // Stand-in datapath: output is correct only on the LAT-th consecutive enabled cycle.
  function automatic logic [53:0] dpf(input logic [62:0] x, input logic [191:0] r);
    logic [53:0] y;
    for (int s = 0; s < 3; s++)
      y[s*18 +: 18] = x[s*21 +: 18] ^ x[s*21+3 +: 18] ^ r[s*32 +: 18] ^ r[(s+3)*32+14 +: 18];
    return y;
  endfunction

  always @(posedge g_clk or posedge g_rst) begin
    if (g_rst)      en_cnt <= 0;
    else if (dp_en) en_cnt <= en_cnt + 1;
    else            en_cnt <= 0;
  end

  assign dp_y = (dp_en && en_cnt == LAT - 1) ? dpf(dp_x, dp_rng) : ~dpf(dp_x, dp_rng);

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] reqs, input int stall_after, input int stall_len,
                        input int hold, input int abort_at, input int fresh_base, output int lane);
    logic [255:0] rx;
    logic [62:0]  x;
    logic [191:0] wpk;
    logic [53:0]  ey;
    logic [3:0]   oh;
    int nw, stalled, t, lat;
    for (int i = 0; i < 8; i++) rx[i*32 +: 32] = $urandom;
    req_x     = rx[251:0];
    req_valid = reqs;
    rsp_ready = '0;
    rng_valid = 1'b0;
    lane = -1;
    for (int k = 0; k < 4; k++)
      if (lane < 0 && reqs[(rr_m + k) % 4]) lane = (rr_m + k) % 4;
    oh = 4'b0001 << lane;
    #1;
    chk("req_ready_grant", req_ready, oh);
    chk("busy_idle", busy, 0);
    x = rx[lane*63 +: 63];
    tick();
    rr_m = (lane + 1) % 4;
    lat  = 1;
    wpk = '0; nw = 0; stalled = 0; t = 0;
    while (nw < 6 && t < 200) begin
      rng_valid = !(nw == stall_after && stalled < stall_len);
      if (!rng_valid) stalled++;
      rng_data = ctr_mode ? ctr : $urandom;
      #1;
      chk("rng_ready_rand", rng_ready, 1);
      chk("dp_en_rand", dp_en, 0);
      chk("req_ready_rand", req_ready, 0);
      if (rng_valid && rng_ready) begin
        wpk[nw*32 +: 32] = rng_data;
        nw++;
        rng_hs++;
        if (ctr_mode) ctr++;
      end
      tick();
      lat++;
      t++;
    end
    chk("rand_words", nw, 6);
    for (int c = 0; c < int'(LAT); c++) begin
      rng_valid = 1'($urandom);
      rng_data  = $urandom;
      #1;
      chk("dp_en_exec", dp_en, 1);
      chk("rng_ready_exec", rng_ready, 0);
      chk("rsp_valid_exec", rsp_valid, 0);
      chk("dp_x", dp_x, x);
      chk("dp_rng", dp_rng, wpk);
      if (c == 0 && fresh_base >= 0)
        for (int k = 0; k < 6; k++) chk("fresh_word", dp_rng[k*32 +: 32], 32'(fresh_base + k));
      if (c == abort_at) begin
        g_rst = 1'b1;
        #1;
        chk("rst_ctrl", {req_ready, rsp_valid, rng_ready, dp_en, busy}, 0);
        chk("rst_dp_x", dp_x, 0);
        chk("rst_dp_rng", dp_rng, 0);
        chk("rst_rsp_y", rsp_y, 0);
        tick();
        tick();
        g_rst = 1'b0;
        rr_m = 0;
        rng_valid = 1'b0;
        return;
      end
      tick();
      lat++;
    end
    rng_valid = 1'b0;
    ey = dpf(x, wpk);
    chk("latency", lat, 1 + RMAX + LAT + stall_len);
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = 4'($urandom) & ~oh;
      if (h == hold) rsp_ready = rsp_ready | oh;
      #1;
      chk("rsp_valid", rsp_valid, oh);
      chk("rsp_y", rsp_y, ey);
      chk("req_ready_resp", req_ready, 0);
      chk("dp_en_resp", dp_en, 0);
      tick();
    end
    rsp_ready = '0;
  endtask

  initial begin
    int l;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    g_rst = 1'b1; req_valid = '0; req_x = '0; rsp_ready = '0; rng_valid = 1'b0; rng_data = '0;
    tick();
    tick();
    req_valid = 4'hF;
    #1;
    chk("reset_ctrl", {req_ready, rsp_valid, rng_ready, dp_en, busy}, 0);
    chk("reset_dp_x", dp_x, 0);
    chk("reset_dp_rng", dp_rng, 0);
    chk("reset_rsp_y", rsp_y, 0);
    req_valid = '0;
    g_rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_op(4'hF, -1, 0, 0, -1, -1, l);
      chk("rr_sequence", l, exp_seq[i]);
    end

    run_op(4'b0100, -1, 0, 0, -1, -1, l);
    chk("single_lane2", l, 2);

    run_op(4'b0010, 3, 20, 0, -1, -1, l);
    chk("starve_lane", l, 1);

    run_op(4'hF, -1, 0, 5, -1, -1, l);
    run_op(4'hF, -1, 0, 0, -1, -1, l);

    for (int i = 0; i < 4; i++)
      run_op(4'($urandom_range(1, 15)), $urandom_range(0, 5), $urandom_range(0, 4),
             $urandom_range(0, 3), -1, -1, l);

    run_op(4'b1000, -1, 0, 0, 1, -1, l);
    req_valid = '0;
    rsp_ready = '1;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("no_rsp_after_reset", {rsp_valid, busy}, 0);
      tick();
    end
    rsp_ready = '0;
    run_op(4'b1000, -1, 0, 0, -1, -1, l);
    chk("post_reset_lane", l, 3);

    ctr_mode = 1'b1;
    ctr = '0;
    rng_hs = 0;
    run_op(4'b0001, -1, 0, 0, -1, 0, l);
    run_op(4'b0001, -1, 0, 0, -1, 6, l);
    chk("rng_handshakes", rng_hs, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sme_sbox_sched.md
Name: sme_sbox_sched

Overview:
- Scheduler sharing one masked inverse-S-box middle stage (sme_sbox_inv_mid, SMAX shares) among NREQ requesters.
- Arbitrates requests round-robin and fetches fresh guard randomness for every operation from an RNG stream.
- Drives the datapath enable for its fixed pipeline latency, then returns the masked result to the granted requester.
- Sits between the masked AES round logic (requesters) and the shared S-box datapath plus the TRNG/PRNG port.

Parameters:
- SMAX, 3, number of masking shares. Derived: RMAX = SMAX+SMAX*(SMAX-1)/2 guard words (6 at default).
- NREQ, 4, number of requesters.
- LAT, 3, datapath latency in cycles; dp_en held high for exactly LAT cycles.
- RW, 32, width of one guard random word.

Ports:
- g_clk  in  1  clock, all state on rising edge.
- g_rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation request.
- req_x  in  NREQ*SMAX*21  per-requester masked 21-bit input shares, requester i at [i*SMAX*21 +: SMAX*21].
- req_ready  out  NREQ  one-hot accept pulse; input is captured on this cycle.
- rsp_valid  out  NREQ  one-hot, result available for that requester.
- rsp_ready  in  NREQ  per-requester result consume.
- rsp_y  out  SMAX*18  masked 18-bit output shares (shared bus, valid while any rsp_valid is set).
- rng_valid  in  1  random word available.
- rng_data  in  RW  random word.
- rng_ready  out  1  random word consumed when rng_valid & rng_ready.
- dp_en  out  1  datapath enable.
- dp_x  out  SMAX*21  datapath input shares.
- dp_rng  out  RMAX*RW  datapath guard randomness, word k at [k*RW +: RW].
- dp_y  in  SMAX*18  datapath output shares.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, RAND, EXEC, RESP.
- Reset (async, g_rst=1) forces:
  - state=IDLE, rr pointer=0, word count=0, exec count=0.
  - dp_x, dp_rng and the rsp_y register cleared to all-zero.
  - req_ready=0, rsp_valid=0, rng_ready=0, dp_en=0, busy=0.
- Reset mid-operation abandons the operation: no response is issued and collected randomness is discarded.
- IDLE:
  - If any req_valid is set, grant the lowest index at or after rr pointer (wrapping modulo NREQ).
  - req_ready[g]=1 combinationally in the same cycle; req_x slice g is registered into dp_x.
  - Register grant index; rr pointer <= g+1 mod NREQ; next state RAND.
  - No req_valid: stay in IDLE.
- RAND:
  - rng_ready=1. Each rng_valid&rng_ready writes rng_data into dp_rng word[count], count++.
  - When the RMAX-th word is taken, count resets to 0 and next state is EXEC.
  - rng_valid low stalls indefinitely with no timeout.
  - Every operation consumes RMAX new words; words are never reused across operations.
- EXEC:
  - dp_en=1 for exactly LAT consecutive cycles; dp_x and dp_rng are held stable throughout.
  - On the last EXEC cycle, register dp_y into rsp_y; next state RESP.
- RESP:
  - rsp_valid[grant]=1 and rsp_y held stable until rsp_ready[grant]=1, then next state IDLE.
  - rsp_ready on non-granted lanes is ignored.
- Outside IDLE, req_ready=0 for all lanes; requests are held off and are not queued.
- Latency with no stalls: request accepted at cycle T, rsp_valid first high at T+1+RMAX+LAT (T+10 at defaults).
- Throughput: at most one operation per 2+RMAX+LAT cycles; the next grant is possible in the cycle after the response handshake.
- Simultaneous req_valid on all lanes: service order is strictly round-robin, e.g. 0,1,2,3,0.
- rr pointer wraps from NREQ-1 to 0.
- dp_en is 0 in every state other than EXEC.
- rsp_y retains its last value after the handshake; only rsp_valid qualifies it.

Decomposition:
- Package sme_pkg holds:
  - localparam function for RMAX(SMAX);
  - state enum {IDLE, RAND, EXEC, RESP};
  - share width constants (21 in, 18 out).
- One natural sub-module: sme_rr_arb (NREQ-wide round-robin arbiter: req vector and pointer in, one-hot grant and next pointer out).

Test Plan:
- Single request, lane 2, rng_valid tied 1, rsp_ready tied 1 (SMAX=3, LAT=3):
  - req_ready[2] pulses at T; dp_en high T+7..T+9; rsp_valid[2] high at T+10.
  - XOR of rsp_y shares equals unmasked riscv_crypto_sbox_inv_mid(x).
- RNG starvation:
  - rng_valid low 20 cycles after word 3 -> FSM stays in RAND, dp_en=0.
  - Resumes and completes after 3 more words; the 6 dp_rng words equal the 6 accepted rng_data values in order.
- All 4 lanes requesting continuously -> grants in order 0,1,2,3,0.
  - Each rsp_valid is one-hot on the matching lane; no lane is granted twice before the others are served.
- Response backpressure:
  - rsp_ready low 5 cycles -> rsp_valid and rsp_y stable, req_ready all 0.
  - After rsp_ready the next grant occurs 1 cycle later.
- Reset during EXEC (cycle 2 of 3):
  - All outputs 0 immediately; no rsp_valid is issued.
  - A new request then performs a full fresh RMAX-word fetch.
- Randomness freshness:
  - Two back-to-back operations with rng_data a counter starting 0x0 -> dp_rng words 0..5 for op 1 and 6..11 for op 2.
  - 12 handshakes total.
